// File: rtl/poly_sub_q_pipe_if.sv
// Stream bundle for the mod-2^NUM_BIT coefficient subtractor: polynomial start,
// x1/x2 input handshake, result handshake and polynomial-level status.
interface poly_sub_q_pipe_if #(
  parameter int NUM_BIT = 13
);
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [NUM_BIT-1:0] x1;
  logic [NUM_BIT-1:0] x2;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_BIT-1:0] out;
  logic               out_last;
  logic               busy;
  logic               done;

  modport master (
    output start, in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, out, out_last, busy, done
  );

  modport slave (
    input  start, in_valid, x1, x2, out_ready,
    output in_ready, out_valid, out, out_last, busy, done
  );
endinterface

// File: rtl/poly_sub_q_pipe.sv
// Streaming coefficient-wise subtractor out = (x1 - x2) mod 2^NUM_BIT over one
// N-coefficient polynomial per start, with a two-stage carry-prefix datapath.
module poly_sub_q_pipe #(
  parameter int NUM_BIT = 13,
  parameter int N       = 701,
  parameter int CNT_W   = 10
) (
  input logic             clk,
  input logic             rst_n,
  poly_sub_q_pipe_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_cnt;

  logic               vld_p0;
  logic               last_p0;
  logic [NUM_BIT-1:0] gen_p0;
  logic [NUM_BIT-1:0] prop_p0;

  logic               vld_p1;
  logic               last_p1;
  logic [NUM_BIT-1:0] sum_p1;

  logic               done_r;
  logic               adv_p0;
  logic               adv_p1;
  logic               in_fire;
  logic               out_fire;
  logic               in_term;
  logic               out_term;

  // Kogge-Stone prefix over (g,p) with carry-in 1 folded into bit 0, so that
  // x1 + ~x2 + 1 is formed without a separate incrementer.
  function automatic logic [NUM_BIT-1:0] resolve_sum(
    input logic [NUM_BIT-1:0] g,
    input logic [NUM_BIT-1:0] p
  );
    logic [NUM_BIT-1:0] gg;
    logic [NUM_BIT-1:0] pp;
    logic [NUM_BIT-1:0] gn;
    logic [NUM_BIT-1:0] pn;
    gg    = g;
    pp    = p;
    gg[0] = g[0] | p[0];
    for (int d = 1; d < NUM_BIT; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < NUM_BIT; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    return p ^ ((gg << 1) | NUM_BIT'(1));
  endfunction

  assign adv_p1   = !vld_p1 || bus.out_ready;
  assign adv_p0   = !vld_p0 || adv_p1;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = vld_p1 && bus.out_ready;
  assign in_term  = in_fire && (in_cnt == LAST_IDX);
  assign out_term = out_fire && (out_cnt == LAST_IDX) && (state == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (in_term)   state_nxt = FLUSH;
      FLUSH:   if (out_term)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == RUN) && adv_p0;
    bus.busy     = (state != IDLE);
  end

  // Counters hold at the terminal index instead of stepping past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end
    end else begin
      if (in_fire && !in_term) in_cnt <= in_cnt + CNT_W'(1);
      if (out_fire && !out_term) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  // Stage 1: generate/propagate of x1 against the inverted subtrahend
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else if (adv_p0) begin
      vld_p0  <= in_fire;
      last_p0 <= in_term;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      gen_p0  <= bus.x1 & ~bus.x2;
      prop_p0 <= bus.x1 ^ ~bus.x2;
    end
  end

  // Stage 2: carry resolution and registered difference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      sum_p1  <= '0;
    end else if (adv_p1) begin
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 && last_p0;
      if (vld_p0) sum_p1 <= resolve_sum(gen_p0, prop_p0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= out_term;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out       = sum_p1;
  assign bus.out_last  = last_p1;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_poly_sub_q_pipe.sv
// Bench for poly_sub_q_pipe: a short-polynomial instance for directed corners
// and the sweep table, and a full-length instance for a randomized stream.
module tb_poly_sub_q_pipe;
  localparam int NB   = 13;
  localparam int NA   = 4;
  localparam int NBIG = 701;

  typedef struct packed {
    logic [NB-1:0] x1;
    logic [NB-1:0] x2;
    logic [NB-1:0] exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_sub_q_pipe_if #(.NUM_BIT(NB)) a_if ();
  poly_sub_q_pipe_if #(.NUM_BIT(NB)) b_if ();

  poly_sub_q_pipe #(.NUM_BIT(NB), .N(NA), .CNT_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  poly_sub_q_pipe #(.NUM_BIT(NB), .N(NBIG), .CNT_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  int total = 0;
  int bad   = 0;
  logic [NB:0] qa[$];
  logic [NB:0] qb[$];
  int a_idx = 0, b_idx = 0, a_done = 0, b_done = 0;
  int b_outs = 0, b_lasts = 0, b_viol = 0, d0 = 0;
  bit b_run = 0, b_rand = 0, hs_a = 0, hs_b = 0, out_a = 0, seen = 0;
  logic [NB:0] out_a_val = '0;
  logic [NB-1:0] pts [5];
  vec_t tbl [28];

  function automatic logic [NB-1:0] ref_sub(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d = d + (1 << NB);
    return NB'(d);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic mon();
    logic [NB:0] e;
    hs_a  = 1'b0;
    hs_b  = 1'b0;
    out_a = 1'b0;
    if (!rst_n) begin
      qa.delete(); qb.delete();
      a_idx = 0; b_idx = 0; b_run = 1'b0;
    end else begin
      if (a_if.in_valid && a_if.in_ready) begin
        qa.push_back({a_idx == NA - 1, ref_sub(a_if.x1, a_if.x2)});
        a_idx = (a_idx == NA - 1) ? 0 : a_idx + 1;
        hs_a  = 1'b1;
      end
      if (a_if.out_valid && a_if.out_ready) begin
        out_a     = 1'b1;
        out_a_val = {a_if.out_last, a_if.out};
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_extra_output: actual=%0d required=none", a_if.out);
        end else begin
          e = qa.pop_front();
          chk("a_stream", {a_if.out_last, a_if.out}, e);
        end
      end
      if (a_if.done) a_done++;
      if (b_if.in_ready && !b_run) b_viol++;
      if (b_if.start && !b_if.busy) b_run = 1'b1;
      if (b_if.in_valid && b_if.in_ready) begin
        qb.push_back({b_idx == NBIG - 1, ref_sub(b_if.x1, b_if.x2)});
        if (b_idx == NBIG - 1) begin
          b_idx = 0; b_run = 1'b0;
        end else begin
          b_idx++;
        end
        hs_b = 1'b1;
      end
      if (b_if.out_valid && b_if.out_ready) begin
        b_outs++;
        if (b_if.out_last) b_lasts++;
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_extra_output: actual=%0d required=none", b_if.out);
        end else begin
          e = qb.pop_front();
          chk("b_stream", {b_if.out_last, b_if.out}, e);
        end
      end
      if (b_if.done) b_done++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (b_rand) b_if.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_a();
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
  endtask

  task automatic send_a(input logic [NB-1:0] v1, input logic [NB-1:0] v2);
    bit got;
    got = 1'b0;
    a_if.x1 = v1; a_if.x2 = v2; a_if.in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      got = hs_a;
    end
    a_if.in_valid = 1'b0;
    chk("a_send_accepted", got, 1);
  endtask

  task automatic send_b(input logic [NB-1:0] v1, input logic [NB-1:0] v2);
    bit got;
    got = 1'b0;
    b_if.x1 = v1; b_if.x2 = v2; b_if.in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      got = hs_b;
    end
    b_if.in_valid = 1'b0;
    chk("b_send_accepted", got, 1);
  endtask

  task automatic wait_done_a();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (a_if.done) got = 1'b1;
      else tick();
    end
    chk("a_done_seen", got, 1);
  endtask

  task automatic wait_done_b();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (b_if.done) got = 1'b1;
      else tick();
    end
    chk("b_done_seen", got, 1);
  endtask

  initial begin
    a_if.start = 1'b0; a_if.in_valid = 1'b0; a_if.x1 = '0; a_if.x2 = '0; a_if.out_ready = 1'b1;
    b_if.start = 1'b0; b_if.in_valid = 1'b0; b_if.x1 = '0; b_if.x2 = '0; b_if.out_ready = 1'b1;
    pts[0] = 13'd0; pts[1] = 13'd1; pts[2] = 13'd4095; pts[3] = 13'd4096; pts[4] = 13'd8191;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        tbl[i*5+j].x1  = pts[i];
        tbl[i*5+j].x2  = pts[j];
        tbl[i*5+j].exp = ref_sub(pts[i], pts[j]);
      end
    end
    for (int k = 25; k < 28; k++) begin
      tbl[k].x1 = '0; tbl[k].x2 = '0; tbl[k].exp = '0;
    end

    repeat (3) tick();
    chk("rst_in_ready", a_if.in_ready, 0);
    chk("rst_out_valid", a_if.out_valid, 0);
    chk("rst_out", a_if.out, 0);
    chk("rst_out_last", a_if.out_last, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    rst_n = 1'b1;
    tick();

    // Back-to-back N=4 polynomial with exact cycle positions
    start_a();
    a_if.x1 = 13'd5; a_if.x2 = 13'd7; a_if.in_valid = 1'b1;
    tick(); chk("t1_hs0", hs_a, 1); chk("t1_valid_c1", a_if.out_valid, 0);
    a_if.x1 = 13'd0; a_if.x2 = 13'd0;
    tick(); chk("t1_hs1", hs_a, 1); chk("t1_valid_c2", a_if.out_valid, 1); chk("t1_out0", a_if.out, 8190);
    a_if.x1 = 13'd8191; a_if.x2 = 13'd0;
    tick(); chk("t1_hs2", hs_a, 1); chk("t1_out1", a_if.out, 0);
    a_if.x1 = 13'd0; a_if.x2 = 13'd8191;
    tick(); chk("t1_hs3", hs_a, 1); chk("t1_flush_in_ready", a_if.in_ready, 0);
    chk("t1_busy", a_if.busy, 1); chk("t1_out2", a_if.out, 8191); chk("t1_last_early", a_if.out_last, 0);
    a_if.in_valid = 1'b0;
    tick(); chk("t1_out3", a_if.out, 1); chk("t1_last", a_if.out_last, 1); chk("t1_done_early", a_if.done, 0);
    d0 = a_done;
    tick(); chk("t1_done", a_if.done, 1); chk("t1_idle", a_if.busy, 0); chk("t1_drained", a_if.out_valid, 0);
    tick(); chk("t1_done_pulse", a_if.done, 0); chk("t1_done_count", a_done - d0, 1);

    // in_valid while IDLE, then start pulsed during RUN
    a_if.x1 = 13'd3; a_if.x2 = 13'd1; a_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_idle_in_ready", a_if.in_ready, 0);
      chk("t4_idle_no_out", a_if.out_valid, 0);
    end
    a_if.in_valid = 1'b0;
    chk("t4_idle_no_queue", qa.size(), 0);
    d0 = a_done;
    start_a();
    send_a(13'd2, 13'd1);
    a_if.start = 1'b1; tick(); a_if.start = 1'b0;
    chk("t4_busy", a_if.busy, 1);
    send_a(13'd20, 13'd10); send_a(13'd30, 13'd40); send_a(13'd8000, 13'd1);
    wait_done_a(); tick();
    chk("t4_done_count", a_done - d0, 1);

    // Output stall with input pressure
    a_if.out_ready = 1'b0;
    start_a();
    send_a(13'd100, 13'd50); send_a(13'd1, 13'd2);
    a_if.x1 = 13'd3; a_if.x2 = 13'd3; a_if.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_stall_in_ready", a_if.in_ready, 0);
      chk("t3_stall_valid", a_if.out_valid, 1);
      chk("t3_stall_out_hold", a_if.out, 50);
    end
    a_if.out_ready = 1'b1;
    send_a(13'd3, 13'd3); send_a(13'd7000, 13'd8000);
    wait_done_a(); tick();

    // Reset after three of four coefficients
    start_a();
    send_a(13'd9, 13'd2); send_a(13'd4, 13'd4); send_a(13'd6, 13'd1);
    d0 = a_done;
    rst_n = 1'b0;
    #1;
    chk("t5_in_ready", a_if.in_ready, 0);
    chk("t5_out_valid", a_if.out_valid, 0);
    chk("t5_out", a_if.out, 0);
    chk("t5_out_last", a_if.out_last, 0);
    chk("t5_busy", a_if.busy, 0);
    chk("t5_done", a_if.done, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_done", a_done - d0, 0);
    d0 = a_done;
    start_a();
    for (int i = 0; i < 4; i++) send_a(13'd10, 13'd3);
    wait_done_a(); tick();
    chk("t5_done_once", a_done - d0, 1);

    // Boundary sweep table, four vectors per polynomial
    for (int i = 0; i < 28; i++) begin
      seen = 1'b0;
      if (i % 4 == 0) start_a();
      send_a(tbl[i].x1, tbl[i].x2);
      for (int k = 0; k < 10 && !seen; k++) begin
        tick();
        seen = out_a;
      end
      chk("sweep_seen", seen, 1);
      chk("sweep_val", out_a_val[NB-1:0], tbl[i].exp);
      chk("sweep_last", out_a_val[NB], (i % 4 == 3) ? 1 : 0);
      if (i % 4 == 3) wait_done_a();
    end
    tick();

    // Full-length polynomial with random bubbles and output stalls
    b_rand = 1'b1;
    b_if.start = 1'b1; tick(); b_if.start = 1'b0;
    for (int i = 0; i < NBIG; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      send_b(NB'($urandom_range(0, 8191)), NB'($urandom_range(0, 8191)));
    end
    wait_done_b();
    b_rand = 1'b0;
    b_if.out_ready = 1'b1;
    repeat (3) tick();
    chk("b_out_count", b_outs, NBIG);
    chk("b_last_count", b_lasts, 1);
    chk("b_done_count", b_done, 1);
    chk("b_in_ready_outside_run", b_viol, 0);
    chk("b_queue_empty", qb.size(), 0);
    chk("a_queue_empty", qa.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
